gauss3x3_blur: RTL and testbench

- Downstream stage of the greyscale conversion in the SIFT front end.
- Reads the 8-bit greyscale frame from the greyscale BRAM through a synchronous read port.
- Applies the separable 3x3 Gaussian kernel [1 2 1; 2 4 2; 1 2 1]/16 with edge clamping.
- Writes the blurred frame, raster order, into a destination BRAM; this is the first scale-space level feeding the DoG stages.

---
 rtl/gauss3x3_blur.sv | 158 +++++++++++++++
 tb/tb_gauss3x3_blur.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss3x3_blur.sv
// Separable 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1]/16, edge-clamped) from the greyscale BRAM into a
// destination BRAM in raster order. Define GAUSS_ROUND_EN for round-half-up output; default truncates.
module gauss3x3_blur #(
   parameter int WIDTH      = 128,
   parameter int HEIGHT     = 128,
   parameter int PIX_W      = 8,
   parameter int RD_LATENCY = 2
) (
   input  logic                            clk_100mhz,
   input  logic                            sys_rst,
   input  logic                            start_in,
   output logic                            busy_out,
   output logic                            done_out,
   output logic [$clog2(WIDTH*HEIGHT)-1:0] src_addr_out,
   input  logic [PIX_W-1:0]                src_data_in,
   output logic [$clog2(WIDTH*HEIGHT)-1:0] dst_addr_out,
   output logic [PIX_W-1:0]                dst_data_out,
   output logic                            dst_we_out
);

   localparam int ADDR_W = $clog2(WIDTH*HEIGHT);
   localparam int X_W    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int Y_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int ACC_W  = PIX_W + 4;

   localparam logic [X_W-1:0] X_MAX        = X_W'(WIDTH - 1);
   localparam logic [Y_W-1:0] Y_MAX        = Y_W'(HEIGHT - 1);
   localparam logic [3:0]     FIRST_SAMPLE = 4'(RD_LATENCY);
   localparam logic [3:0]     LAST_SAMPLE  = 4'(8 + RD_LATENCY);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state;
   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic [3:0]        cyc;
   logic [ACC_W-1:0]  acc;
   logic [ADDR_W-1:0] addr_hold;

   logic [1:0]        dx_sel, dy_sel;
   logic [X_W-1:0]    cx;
   logic [Y_W-1:0]    cy;
   logic [ADDR_W-1:0] cur_addr;
   logic [3:0]        sample_k;
   logic              sampling;
   logic [PIX_W-1:0]  pix;

   // Tap k in row-major order -> {dy_sel, dx_sel}, where 0/1/2 mean -1/0/+1.
   function automatic logic [3:0] tap_pos(input logic [3:0] k);
      case (k)
         4'd0:    tap_pos = {2'd0, 2'd0};
         4'd1:    tap_pos = {2'd0, 2'd1};
         4'd2:    tap_pos = {2'd0, 2'd2};
         4'd3:    tap_pos = {2'd1, 2'd0};
         4'd4:    tap_pos = {2'd1, 2'd1};
         4'd5:    tap_pos = {2'd1, 2'd2};
         4'd6:    tap_pos = {2'd2, 2'd0};
         4'd7:    tap_pos = {2'd2, 2'd1};
         default: tap_pos = {2'd2, 2'd2};
      endcase
   endfunction

   // Kernel weight as a left shift: centre 4, edges 2, corners 1.
   function automatic logic [1:0] tap_shift(input logic [3:0] k);
      case (k)
         4'd4:                     tap_shift = 2'd2;
         4'd1, 4'd3, 4'd5, 4'd7:   tap_shift = 2'd1;
         default:                  tap_shift = 2'd0;
      endcase
   endfunction

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      {dy_sel, dx_sel} = tap_pos(cyc);
      cx = x;
      cy = y;
      if (dx_sel == 2'd0 && x != '0)         cx = x - X_W'(1);
      else if (dx_sel == 2'd2 && x != X_MAX) cx = x + X_W'(1);
      if (dy_sel == 2'd0 && y != '0)         cy = y - Y_W'(1);
      else if (dy_sel == 2'd2 && y != Y_MAX) cy = y + Y_W'(1);
   end

   assign cur_addr = ADDR_W'(cy) * ADDR_W'(WIDTH) + ADDR_W'(cx);
   assign sample_k = cyc - FIRST_SAMPLE;
   assign sampling = (state == S_READ || state == S_DRAIN) &&
                     cyc >= FIRST_SAMPLE && cyc <= LAST_SAMPLE;

`ifdef GAUSS_ROUND_EN
   assign pix = PIX_W'((acc + ACC_W'(8)) >> 4);
`else
   assign pix = PIX_W'(acc >> 4);
`endif

   assign busy_out     = (state != S_IDLE);
   assign done_out     = (state == S_DONE);
   assign dst_we_out   = (state == S_WRITE);
   assign dst_addr_out = dst_we_out ? ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x) : '0;
   assign dst_data_out = dst_we_out ? pix : '0;
   assign src_addr_out = (state == S_READ) ? cur_addr : addr_hold;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_100mhz or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= S_IDLE;
         x         <= '0;
         y         <= '0;
         cyc       <= '0;
         acc       <= '0;
         addr_hold <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_in) begin
                  state <= S_READ;
                  x     <= '0;
                  y     <= '0;
                  cyc   <= '0;
                  acc   <= '0;
               end
            end
            S_READ: begin
               addr_hold <= cur_addr;
               cyc       <= cyc + 4'd1;
               if (cyc == 4'd8) state <= S_DRAIN;
            end
            S_DRAIN: begin
               cyc <= cyc + 4'd1;
               if (cyc == LAST_SAMPLE) state <= S_WRITE;
            end
            S_WRITE: begin
               cyc <= '0;
               acc <= '0;
               if (x == X_MAX) begin
                  x <= '0;
                  if (y == Y_MAX) begin
                     state <= S_DONE;
                  end else begin
                     y     <= y + Y_W'(1);
                     state <= S_READ;
                  end
               end else begin
                  x     <= x + X_W'(1);
                  state <= S_READ;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
         // Never overlaps the clear in WRITE: the last sample lands one cycle earlier.
         if (sampling) acc <= acc + (ACC_W'(src_data_in) << tap_shift(sample_k));
      end
   end

endmodule

// File: tb/tb_gauss3x3_blur.sv
// Bench for gauss3x3_blur: two instances (RD_LATENCY 2 and 4) on an 8x6 frame, a direct blur
// model, literal expectations for the constant/impulse/corner frames, and one negedge compare process.
`timescale 1ns/1ps
module tb_gauss3x3_blur;

   localparam int W     = 8;
   localparam int H     = 6;
   localparam int N     = W * H;
   localparam int AW    = $clog2(N);
   localparam int IMP_X = 4;
   localparam int IMP_Y = 3;
   localparam int LIMIT = N * 14 + 200;

`ifdef GAUSS_ROUND_EN
   localparam int IMP_C = 64, IMP_E = 32, IMP_D = 16;
`else
   localparam int IMP_C = 63, IMP_E = 31, IMP_D = 15;
`endif

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic start = 1'b0;

   logic          busy  [2];
   logic          done  [2];
   logic          we    [2];
   logic [AW-1:0] saddr [2];
   logic [AW-1:0] daddr [2];
   logic [7:0]    sdata [2];
   logic [7:0]    ddata [2];

   logic [7:0] src_mem [N];
   int         exp_mem [N];
   int         lit_val [N];
   bit         lit_ok  [N];
   bit         timeout_flag = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int RL = (g == 0) ? 2 : 4;
      logic [7:0] pipe [RL];

      // Synchronous-read BRAM with RL cycles from address to data.
      always @(posedge clk) begin
         pipe[0] <= src_mem[saddr[g]];
         for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
      end
      assign sdata[g] = pipe[RL-1];

      gauss3x3_blur #(.WIDTH(W), .HEIGHT(H), .PIX_W(8), .RD_LATENCY(RL)) dut (
         .clk_100mhz   (clk),
         .sys_rst      (rst),
         .start_in     (start),
         .busy_out     (busy[g]),
         .done_out     (done[g]),
         .src_addr_out (saddr[g]),
         .src_data_in  (sdata[g]),
         .dst_addr_out (daddr[g]),
         .dst_data_out (ddata[g]),
         .dst_we_out   (we[g])
      );
   end

   function automatic int rl_of(input int i);
      return (i == 0) ? 2 : 4;
   endfunction

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : (v > hi) ? hi : v;
   endfunction

   // Weighted 3x3 sum over the clamped neighbourhood, then /16.
   function automatic int blur_ref(input int x, input int y);
      int s, w;
      s = 0;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++) begin
            w = ((dx == 0) ? 2 : 1) * ((dy == 0) ? 2 : 1);
            s += w * int'(src_mem[clampi(y + dy, H - 1) * W + clampi(x + dx, W - 1)]);
         end
`ifdef GAUSS_ROUND_EN
      return (s + 8) / 16;
`else
      return s / 16;
`endif
   endfunction

   task automatic check(input string name, input int i, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s (rd_latency=%0d) at %0t: got %0d, expected %0d", name, rl_of(i), $time, act, exp);
      end
   endtask

   // Frame kinds: 0 constant 100, 1 impulse, 2 two clamped corners, 3 pattern with a saturated row.
   task automatic load(input int kind);
      int a;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            a = y * W + x;
            case (kind)
               0:       src_mem[a] = 8'd100;
               1:       src_mem[a] = (x == IMP_X && y == IMP_Y) ? 8'd255 : 8'd0;
               2:       src_mem[a] = ((x == 0 && y == 0) || (x == W-1 && y == H-1)) ? 8'd160 : 8'd0;
               default: src_mem[a] = (y == 2) ? 8'd255 : 8'((x * 53 + y * 97 + x * y * 7) % 256);
            endcase
            lit_ok[a]  = (kind <= 2);
            lit_val[a] = (kind == 0) ? 100 : 0;
         end
      if (kind == 1) begin
         for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
               lit_val[(IMP_Y + dy) * W + IMP_X + dx] =
                  (dx == 0 && dy == 0) ? IMP_C : (dx == 0 || dy == 0) ? IMP_E : IMP_D;
      end
      if (kind == 2) begin
         lit_val[0]                   = 90;
         lit_val[1]                   = 30;
         lit_val[W]                   = 30;
         lit_val[W + 1]               = 10;
         lit_val[N - 1]               = 90;
         lit_val[N - 2]               = 30;
         lit_val[N - 1 - W]           = 30;
         lit_val[N - 2 - W]           = 10;
      end
      for (int k = 0; k < N; k++) exp_mem[k] = blur_ref(k % W, k / W);
   endtask

   // Sole compare process: reset state, write address/data/timing, done and busy framing.
   int cycle = 0;
   int wr_cnt [2], last_wr [2], start_cyc [2], done_in_frame [2], done_seen [2];
   bit busy_q [2], post_done [2];
   bit timeout_seen = 1'b0;

   initial begin : compare
      forever begin
         @(negedge clk);
         cycle++;
         if (timeout_flag && !timeout_seen) begin
            timeout_seen = 1'b1;
            check("frame_timeout", 0, int'(timeout_flag), 0);
         end
         for (int i = 0; i < 2; i++) begin
            if (rst) begin
               check("reset_outputs_zero", i,
                     int'({busy[i], done[i], we[i], saddr[i], daddr[i], ddata[i]}), 0);
               busy_q[i]    = 1'b0;
               post_done[i] = 1'b0;
            end else begin
               if (post_done[i]) begin
                  check("busy_low_after_done", i, int'(busy[i]), 0);
                  post_done[i] = 1'b0;
               end
               if (busy[i] && !busy_q[i]) begin
                  start_cyc[i]     = cycle;
                  wr_cnt[i]        = 0;
                  done_in_frame[i] = 0;
               end
               if (!busy[i]) check("idle_we_done_low", i, int'({we[i], done[i]}), 0);
               if (we[i]) begin
                  if (wr_cnt[i] == 0) check("first_write_latency", i, cycle - start_cyc[i], 9 + rl_of(i));
                  else                check("write_spacing", i, cycle - last_wr[i], 10 + rl_of(i));
                  check("dst_addr_raster", i, int'(daddr[i]), wr_cnt[i]);
                  if (wr_cnt[i] < N) begin
                     check("dst_data_vs_model", i, int'(ddata[i]), exp_mem[wr_cnt[i]]);
                     if (lit_ok[wr_cnt[i]]) begin
                        check("dst_data_vs_literal", i, int'(ddata[i]), lit_val[wr_cnt[i]]);
                        check("model_vs_literal", i, exp_mem[wr_cnt[i]], lit_val[wr_cnt[i]]);
                     end
                  end
                  last_wr[i] = cycle;
                  wr_cnt[i]++;
               end
               if (done[i]) begin
                  check("write_count_at_done", i, wr_cnt[i], N);
                  check("done_after_last_write", i, cycle - last_wr[i], 1);
                  check("single_done_per_frame", i, done_in_frame[i], 0);
                  check("busy_high_in_done", i, int'(busy[i]), 1);
                  done_in_frame[i]++;
                  done_seen[i]++;
                  post_done[i] = 1'b1;
               end
               busy_q[i] = busy[i];
            end
         end
      end
   end

   // One frame on both instances; optionally re-pulse start mid-frame or in instance 0's DONE cycle.
   task automatic run_frame(input bit poke_done, input int busy_poke);
      int d0, d1, n;
      d0 = done_seen[0];
      d1 = done_seen[1];
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0;
      while ((done_seen[0] == d0 || done_seen[1] == d1) && n < LIMIT) begin
         @(negedge clk);
         n++;
         start = (n == busy_poke) || (poke_done && done[0]);
      end
      start = 1'b0;
      if (n >= LIMIT) timeout_flag = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin : main
      load(0);
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk) #2 rst = 1'b0;
      repeat (2) @(negedge clk);

      run_frame(1'b1, 0);          // constant; start offered in the DONE cycle
      load(1);
      run_frame(1'b0, 0);          // impulse
      load(2);
      run_frame(1'b0, 0);          // clamped corners
      load(3);
      run_frame(1'b0, N * 6);      // pattern; second start while busy

      // Abandon a frame partway, then prove a clean restart.
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (20 * 12) @(negedge clk);
      @(posedge clk) #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk) #2 rst = 1'b0;
      repeat (30) @(negedge clk);
      load(0);
      run_frame(1'b0, 0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
